// File: rtl/conv_lane_serializer.sv
// conv_lane_serializer: captures the parallel conv_unit output lanes as one word
// per cycle into a FIFO, then replays the valid lanes of each word as a single
// serial AXI-stream. conv_unit cannot be stalled by ready, so it is throttled
// through upstream_en while enough headroom remains for its in-flight results.
module conv_lane_serializer #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_W_MAX = 3,
  parameter int TUSER_WIDTH  = 4,
  parameter int DEPTH        = 32,
  parameter int MARGIN       = 27
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic [KERNEL_W_MAX-1:0]                   s_valid,
  input  logic [KERNEL_W_MAX-1:0][DATA_WIDTH-1:0]   s_data,
  input  logic [KERNEL_W_MAX-1:0]                   s_last,
  input  logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0]  s_user,
  output logic                                      upstream_en,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [DATA_WIDTH-1:0]                     m_data,
  output logic                                      m_last,
  output logic [TUSER_WIDTH-1:0]                    m_user,
  output logic                                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (KERNEL_W_MAX > 1) ? $clog2(KERNEL_W_MAX) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - MARGIN);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  typedef logic [KERNEL_W_MAX-1:0][DATA_WIDTH-1:0]  data_vec_t;
  typedef logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0] user_vec_t;

  // Lowest set lane of a mask (0 when the mask is empty).
  function automatic logic [LW-1:0] f_lowest(input logic [KERNEL_W_MAX-1:0] m);
    f_lowest = '0;
    for (int i = KERNEL_W_MAX - 1; i >= 0; i--)
      if (m[i]) f_lowest = LW'(i);
  endfunction

  // True when some lane above 'lane' is set in the mask.
  function automatic logic f_has_above(input logic [KERNEL_W_MAX-1:0] m,
                                       input logic [LW-1:0] lane);
    f_has_above = 1'b0;
    for (int i = 0; i < KERNEL_W_MAX; i++)
      if (m[i] && (i > int'(lane))) f_has_above = 1'b1;
  endfunction

  // Nearest set lane above 'lane'; only meaningful when f_has_above is true.
  function automatic logic [LW-1:0] f_next_above(input logic [KERNEL_W_MAX-1:0] m,
                                                 input logic [LW-1:0] lane);
    f_next_above = lane;
    for (int i = KERNEL_W_MAX - 1; i >= 0; i--)
      if (m[i] && (i > int'(lane))) f_next_above = LW'(i);
  endfunction

  // Word storage: data path only, never reset.
  data_vec_t               r_mem_data  [DEPTH];
  user_vec_t               r_mem_user  [DEPTH];
  logic [KERNEL_W_MAX-1:0] r_mem_mask  [DEPTH];
  logic                    r_mem_wlast [DEPTH];

  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [LW-1:0]   r_lane;
  state_t          r_state;
  logic            r_up_en, r_overflow, r_m_last;
  logic [DATA_WIDTH-1:0]  r_m_data;
  logic [TUSER_WIDTH-1:0] r_m_user;

  logic                    w_push, w_in_wlast, w_more, w_hs, w_pop, w_accept;
  logic [CW-1:0]           w_count_nxt;
  logic [KERNEL_W_MAX-1:0] w_head_mask;
  logic                    w_head_wlast;
  state_t                  w_state_nxt;
  logic                    w_load, w_adv, w_src_in;
  logic [AW-1:0]           w_src_ptr;
  logic [KERNEL_W_MAX-1:0] w_src_mask;
  data_vec_t               w_src_data;
  user_vec_t               w_src_user;
  logic                    w_src_wlast;
  logic [LW-1:0]           w_load_lane, w_adv_lane;

  assign w_push       = |s_valid;
  assign w_in_wlast   = |(s_valid & s_last);
  assign w_head_mask  = r_mem_mask[r_rd_ptr];
  assign w_head_wlast = r_mem_wlast[r_rd_ptr];
  assign w_more       = f_has_above(w_head_mask, r_lane);
  assign w_hs         = (r_state == S_EMIT) && m_ready;
  assign w_pop        = w_hs && !w_more;
  // A full FIFO still takes a word when the head is retired on the same edge.
  assign w_accept     = w_push && ((r_count < DEPTH_C) || w_pop);
  assign w_count_nxt  = r_count + CW'(w_accept) - CW'(w_pop);

  // Output FSM next state and selection of the word the output register loads from.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_src_in    = 1'b0;
    w_src_ptr   = r_rd_ptr;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_EMIT;
          w_load      = 1'b1;
        end
      end
      S_EMIT: begin
        if (w_hs) begin
          if (w_more) begin
            w_adv = 1'b1;
          end else if (r_count > CW'(1)) begin
            w_load    = 1'b1;
            w_src_ptr = r_rd_ptr + 1'b1;
          end else if (w_accept) begin
            // Only stored word is leaving; the word arriving now follows without a bubble.
            w_load   = 1'b1;
            w_src_in = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Source word for a load: either the stored word at w_src_ptr or the incoming lanes.
  always_comb begin
    w_src_mask  = r_mem_mask[w_src_ptr];
    w_src_data  = r_mem_data[w_src_ptr];
    w_src_user  = r_mem_user[w_src_ptr];
    w_src_wlast = r_mem_wlast[w_src_ptr];
    if (w_src_in) begin
      w_src_mask  = s_valid;
      w_src_data  = s_data;
      w_src_user  = s_user;
      w_src_wlast = w_in_wlast;
    end
  end

  assign w_load_lane = f_lowest(w_src_mask);
  assign w_adv_lane  = f_next_above(w_head_mask, r_lane);

  // FIFO word storage write.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_mem_data[r_wr_ptr]  <= s_data;
      r_mem_user[r_wr_ptr]  <= s_user;
      r_mem_mask[r_wr_ptr]  <= s_valid;
      r_mem_wlast[r_wr_ptr] <= w_in_wlast;
    end
  end

  // FIFO pointers, occupancy, throttle and sticky overflow.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_up_en    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_up_en <= (w_count_nxt <= THRESH_C);
      if (w_push && !w_accept) r_overflow <= 1'b1;
    end
  end

  // Output FSM state, lane pointer and output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_lane   <= '0;
      r_m_data <= '0;
      r_m_user <= '0;
      r_m_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_lane   <= w_load_lane;
        r_m_data <= w_src_data[w_load_lane];
        r_m_user <= w_src_user[w_load_lane];
        r_m_last <= w_src_wlast && !f_has_above(w_src_mask, w_load_lane);
      end else if (w_adv) begin
        r_lane   <= w_adv_lane;
        r_m_data <= r_mem_data[r_rd_ptr][w_adv_lane];
        r_m_user <= r_mem_user[r_rd_ptr][w_adv_lane];
        r_m_last <= w_head_wlast && !f_has_above(w_head_mask, w_adv_lane);
      end
    end
  end

  assign m_valid     = (r_state == S_EMIT);
  assign m_data      = r_m_data;
  assign m_user      = r_m_user;
  assign m_last      = r_m_last;
  assign upstream_en = r_up_en;
  assign overflow    = r_overflow;

endmodule
